// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//
// AXI4 slave memory model used as the far end of a compute core's memory port
// in block-level simulations. Bursts are backed by an internal array of
// 2**DEPTH_LOG2 words of 256 bits. The read and write channels are served by
// independent FSMs, each allowing one outstanding burst.
//
// Parameters:
//   DEPTH_LOG2  log2 of the memory depth in 256-bit words
//   LFSR_SEED   seed of the stall LFSR (only used with AXI_MEM_RAND_STALL_EN)
//
// Ports:
//   clock, reset               sole clock (rising edge), synchronous active-high reset
//   io_axi_aw_*                write address channel (ready out, rest in)
//   io_axi_w_*                 write data channel (ready out, rest in)
//   io_axi_b_*                 write response channel (ready in, rest out)
//   io_axi_ar_*                read address channel (ready out, rest in)
//   io_axi_r_*                 read data channel (ready in, rest out)
//
// Only INCR bursts of 32-byte beats inside the array are serviced; anything
// else is answered with SLVERR (writes dropped, read data zero).
//
// Optional feature macro: AXI_MEM_RAND_STALL_EN
//   When defined, a 16-bit LFSR randomly withholds ready/valid assertions to
//   exercise back-pressure in the master. Undefined: no stalls are inserted.
// -----------------------------------------------------------------------------
module axi_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic         clock,
  input  logic         reset,
  output logic         io_axi_aw_ready,
  input  logic         io_axi_aw_valid,
  input  logic [32:0]  io_axi_aw_bits_addr,
  input  logic [1:0]   io_axi_aw_bits_burst,
  input  logic [5:0]   io_axi_aw_bits_id,
  input  logic [3:0]   io_axi_aw_bits_len,
  input  logic [2:0]   io_axi_aw_bits_size,
  output logic         io_axi_w_ready,
  input  logic         io_axi_w_valid,
  input  logic         io_axi_w_bits_last,
  input  logic [255:0] io_axi_w_bits_data,
  input  logic [31:0]  io_axi_w_bits_strb,
  input  logic         io_axi_b_ready,
  output logic         io_axi_b_valid,
  output logic [5:0]   io_axi_b_bits_id,
  output logic [1:0]   io_axi_b_bits_resp,
  output logic         io_axi_ar_ready,
  input  logic         io_axi_ar_valid,
  input  logic [32:0]  io_axi_ar_bits_addr,
  input  logic [1:0]   io_axi_ar_bits_burst,
  input  logic [5:0]   io_axi_ar_bits_id,
  input  logic [3:0]   io_axi_ar_bits_len,
  input  logic [2:0]   io_axi_ar_bits_size,
  input  logic         io_axi_r_ready,
  output logic         io_axi_r_valid,
  output logic [255:0] io_axi_r_bits_data,
  output logic         io_axi_r_bits_last,
  output logic [5:0]   io_axi_r_bits_id,
  output logic [1:0]   io_axi_r_bits_resp
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic [255:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx, r_idx, r_idx_next;
  logic [3:0]            w_len, w_cnt, r_len, r_cnt;
  logic [5:0]            w_id, r_id;
  logic                  w_addr_err, w_last_err, r_err;
  logic [255:0]          r_data;
  logic [255:0]          w_merged;
  logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic                  w_beat_last, r_beat_last;
  logic                  gate_aw, gate_w, gate_b, gate_ar, gate_r;

  // Unsupported burst type, beat size, or an address beyond the array.
  function automatic logic req_error(input logic [1:0]  burst,
                                     input logic [2:0]  size,
                                     input logic [32:0] addr);
    return (burst != 2'b01) || (size != 3'd5) || ((addr >> (5 + DEPTH_LOG2)) != 33'd0);
  endfunction

`ifdef AXI_MEM_RAND_STALL_EN
  logic [15:0] lfsr;
  logic        b_held, r_held;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, stepped every cycle.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // A raised valid must stay up until its handshake, regardless of the LFSR.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_held <= 1'b0;
      r_held <= 1'b0;
    end else begin
      b_held <= io_axi_b_valid && !io_axi_b_ready;
      r_held <= io_axi_r_valid && !io_axi_r_ready;
    end
  end

  assign gate_aw = lfsr[0];
  assign gate_w  = lfsr[3];
  assign gate_ar = lfsr[5];
  assign gate_r  = lfsr[7] | r_held;
  assign gate_b  = lfsr[9] | b_held;
`else
  assign gate_aw = 1'b1;
  assign gate_w  = 1'b1;
  assign gate_ar = 1'b1;
  assign gate_r  = 1'b1;
  assign gate_b  = 1'b1;
`endif

  assign aw_fire     = io_axi_aw_valid && io_axi_aw_ready;
  assign w_fire      = io_axi_w_valid  && io_axi_w_ready;
  assign b_fire      = io_axi_b_valid  && io_axi_b_ready;
  assign ar_fire     = io_axi_ar_valid && io_axi_ar_ready;
  assign r_fire      = io_axi_r_valid  && io_axi_r_ready;
  assign w_beat_last = (w_cnt == w_len);
  assign r_beat_last = (r_cnt == r_len);
  assign r_idx_next  = r_idx + 1'b1;

  // ---------------- write FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_next = W_DATA;
      W_DATA:  if (w_fire && w_beat_last) w_state_next = W_RESP;
      W_RESP:  if (b_fire) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    io_axi_aw_ready    = !reset && (w_state == W_IDLE) && gate_aw;
    io_axi_w_ready     = !reset && (w_state == W_DATA) && gate_w;
    io_axi_b_valid     = !reset && (w_state == W_RESP) && gate_b;
    io_axi_b_bits_id   = w_id;
    io_axi_b_bits_resp = (w_addr_err || w_last_err) ? 2'b10 : 2'b00;
  end

  // The burst length alone ends the burst; a w_last that disagrees with the
  // beat count only poisons the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_idx      <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_id       <= '0;
      w_addr_err <= 1'b0;
      w_last_err <= 1'b0;
    end else if (aw_fire) begin
      w_idx      <= io_axi_aw_bits_addr[5 +: DEPTH_LOG2];
      w_len      <= io_axi_aw_bits_len;
      w_cnt      <= '0;
      w_id       <= io_axi_aw_bits_id;
      w_addr_err <= req_error(io_axi_aw_bits_burst, io_axi_aw_bits_size, io_axi_aw_bits_addr);
      w_last_err <= 1'b0;
    end else if (w_fire) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 1'b1;
      if (io_axi_w_bits_last != w_beat_last) w_last_err <= 1'b1;
    end
  end

  always_comb begin
    w_merged = mem[w_idx];
    for (int i = 0; i < 32; i++) begin
      if (io_axi_w_bits_strb[i]) w_merged[8*i +: 8] = io_axi_w_bits_data[8*i +: 8];
    end
  end

  // Memory is deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (w_fire && !w_addr_err) mem[w_idx] <= w_merged;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_next = R_DATA;
      R_DATA:  if (r_fire && r_beat_last) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    io_axi_ar_ready    = !reset && (r_state == R_IDLE) && gate_ar;
    io_axi_r_valid     = !reset && (r_state == R_DATA) && gate_r;
    io_axi_r_bits_data = r_data;
    io_axi_r_bits_last = (r_state == R_DATA) && r_beat_last;
    io_axi_r_bits_id   = r_id;
    io_axi_r_bits_resp = r_err ? 2'b10 : 2'b00;
  end

  // The next word is fetched on the handshake edge, so a write to the same
  // index in that cycle is not yet visible: the read returns pre-write data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_id   <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if (ar_fire) begin
      r_idx  <= io_axi_ar_bits_addr[5 +: DEPTH_LOG2];
      r_len  <= io_axi_ar_bits_len;
      r_cnt  <= '0;
      r_id   <= io_axi_ar_bits_id;
      r_err  <= req_error(io_axi_ar_bits_burst, io_axi_ar_bits_size, io_axi_ar_bits_addr);
      r_data <= req_error(io_axi_ar_bits_burst, io_axi_ar_bits_size, io_axi_ar_bits_addr)
                ? '0 : mem[io_axi_ar_bits_addr[5 +: DEPTH_LOG2]];
    end else if (r_fire && !r_beat_last) begin
      r_idx  <= r_idx_next;
      r_cnt  <= r_cnt + 1'b1;
      r_data <= r_err ? '0 : mem[r_idx_next];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder. Expected B responses and R beats
// are pushed to queues when a transaction is issued and popped by a monitor
// when the DUT presents them. A reference memory predicts read data.
module tb_axi_mem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int TIMEOUT    = 200;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_axi_aw_ready, io_axi_aw_valid;
  logic [32:0]  io_axi_aw_bits_addr;
  logic [1:0]   io_axi_aw_bits_burst;
  logic [5:0]   io_axi_aw_bits_id;
  logic [3:0]   io_axi_aw_bits_len;
  logic [2:0]   io_axi_aw_bits_size;
  logic         io_axi_w_ready, io_axi_w_valid, io_axi_w_bits_last;
  logic [255:0] io_axi_w_bits_data;
  logic [31:0]  io_axi_w_bits_strb;
  logic         io_axi_b_ready, io_axi_b_valid;
  logic [5:0]   io_axi_b_bits_id;
  logic [1:0]   io_axi_b_bits_resp;
  logic         io_axi_ar_ready, io_axi_ar_valid;
  logic [32:0]  io_axi_ar_bits_addr;
  logic [1:0]   io_axi_ar_bits_burst;
  logic [5:0]   io_axi_ar_bits_id;
  logic [3:0]   io_axi_ar_bits_len;
  logic [2:0]   io_axi_ar_bits_size;
  logic         io_axi_r_ready, io_axi_r_valid;
  logic [255:0] io_axi_r_bits_data;
  logic         io_axi_r_bits_last;
  logic [5:0]   io_axi_r_bits_id;
  logic [1:0]   io_axi_r_bits_resp;

  always #5 clock = ~clock;

  axi_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset),
    .io_axi_aw_ready(io_axi_aw_ready), .io_axi_aw_valid(io_axi_aw_valid),
    .io_axi_aw_bits_addr(io_axi_aw_bits_addr), .io_axi_aw_bits_burst(io_axi_aw_bits_burst),
    .io_axi_aw_bits_id(io_axi_aw_bits_id), .io_axi_aw_bits_len(io_axi_aw_bits_len),
    .io_axi_aw_bits_size(io_axi_aw_bits_size),
    .io_axi_w_ready(io_axi_w_ready), .io_axi_w_valid(io_axi_w_valid),
    .io_axi_w_bits_last(io_axi_w_bits_last), .io_axi_w_bits_data(io_axi_w_bits_data),
    .io_axi_w_bits_strb(io_axi_w_bits_strb),
    .io_axi_b_ready(io_axi_b_ready), .io_axi_b_valid(io_axi_b_valid),
    .io_axi_b_bits_id(io_axi_b_bits_id), .io_axi_b_bits_resp(io_axi_b_bits_resp),
    .io_axi_ar_ready(io_axi_ar_ready), .io_axi_ar_valid(io_axi_ar_valid),
    .io_axi_ar_bits_addr(io_axi_ar_bits_addr), .io_axi_ar_bits_burst(io_axi_ar_bits_burst),
    .io_axi_ar_bits_id(io_axi_ar_bits_id), .io_axi_ar_bits_len(io_axi_ar_bits_len),
    .io_axi_ar_bits_size(io_axi_ar_bits_size),
    .io_axi_r_ready(io_axi_r_ready), .io_axi_r_valid(io_axi_r_valid),
    .io_axi_r_bits_data(io_axi_r_bits_data), .io_axi_r_bits_last(io_axi_r_bits_last),
    .io_axi_r_bits_id(io_axi_r_bits_id), .io_axi_r_bits_resp(io_axi_r_bits_resp)
  );

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
    logic [5:0]   id;
    logic [1:0]   resp;
  } r_exp_t;

  b_exp_t       b_queue [$];
  r_exp_t       r_queue [$];
  logic [255:0] ref_mem [DEPTH];
  int           checks = 0;
  int           errors = 0;
  int           r_seen = 0;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic spec_error(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [32:0] addr);
    return (burst != 2'b01) || (size != 3'd5) || (addr[32:5+DEPTH_LOG2] != '0);
  endfunction

  function automatic logic [255:0] merge_bytes(input logic [255:0] old_word,
                                               input logic [255:0] data, input logic [31:0] strb);
    logic [255:0] result;
    result = old_word;
    for (int i = 0; i < 32; i++) if (strb[i]) result[8*i +: 8] = data[8*i +: 8];
    return result;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic readyOf(input int ch);
    case (ch)
      0:       return io_axi_aw_ready;
      1:       return io_axi_w_ready;
      default: return io_axi_ar_ready;
    endcase
  endfunction

  // Returns just after the posedge on which the handshake took place.
  task automatic waitHandshake(input string tag, input int ch);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!readyOf(ch) && n < TIMEOUT);
    if (!readyOf(ch)) checkOutput({tag, "_timeout"}, 256'(0), 256'(1));
    @(posedge clock);
    #1;
  endtask

  // Response/data monitor, sampling on the falling edge.
  always @(negedge clock) begin
    b_exp_t be;
    r_exp_t re;
    if (!reset) begin
      if (io_axi_b_valid && io_axi_b_ready) begin
        if (b_queue.size() == 0) checkOutput("b_unexpected", 256'(1), 256'(0));
        else begin
          be = b_queue.pop_front();
          checkOutput("b_id", 256'(io_axi_b_bits_id), 256'(be.id));
          checkOutput("b_resp", 256'(io_axi_b_bits_resp), 256'(be.resp));
        end
      end
      if (io_axi_r_valid && io_axi_r_ready) begin
        if (r_queue.size() == 0) checkOutput("r_unexpected", 256'(1), 256'(0));
        else begin
          re = r_queue.pop_front();
          checkOutput("r_data", io_axi_r_bits_data, re.data);
          checkOutput("r_last", 256'(io_axi_r_bits_last), 256'(re.last));
          checkOutput("r_id", 256'(io_axi_r_bits_id), 256'(re.id));
          checkOutput("r_resp", 256'(io_axi_r_bits_resp), 256'(re.resp));
          r_seen++;
        end
      end else if (io_axi_r_valid && !io_axi_r_ready && r_queue.size() != 0) begin
        re = r_queue[0];
        checkOutput("r_data_stall", io_axi_r_bits_data, re.data);
        checkOutput("r_last_stall", 256'(io_axi_r_bits_last), 256'(re.last));
      end
    end
  end

  // last_beat: the beat index that carries w_last (-1 for none).
  task automatic applyStimulus_write(input logic [32:0] addr, input logic [1:0] burst,
                                     input logic [2:0] size, input logic [3:0] len,
                                     input logic [5:0] id, input logic [31:0] strb,
                                     input int last_beat, input logic use_fixed,
                                     input logic [255:0] fixed_data);
    logic         err;
    int           idx;
    int           n;
    logic [255:0] data;
    err = spec_error(burst, size, addr);
    idx = int'(addr[5 +: DEPTH_LOG2]);
    b_queue.push_back('{id: id, resp: (err || last_beat != int'(len)) ? 2'b10 : 2'b00});
    io_axi_aw_valid      = 1'b1;
    io_axi_aw_bits_addr  = addr;
    io_axi_aw_bits_burst = burst;
    io_axi_aw_bits_size  = size;
    io_axi_aw_bits_len   = len;
    io_axi_aw_bits_id    = id;
    waitHandshake("aw", 0);
    io_axi_aw_valid = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      data = use_fixed ? fixed_data : rand256();
      io_axi_w_valid     = 1'b1;
      io_axi_w_bits_data = data;
      io_axi_w_bits_strb = strb;
      io_axi_w_bits_last = (beat == last_beat);
      waitHandshake("w", 1);
      if (!err) ref_mem[idx] = merge_bytes(ref_mem[idx], data, strb);
      idx = (idx + 1) % DEPTH;
    end
    io_axi_w_valid     = 1'b0;
    io_axi_w_bits_last = 1'b0;
    n = 0;
    while (b_queue.size() != 0 && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    if (b_queue.size() != 0) begin
      checkOutput("b_timeout", 256'(b_queue.size()), 256'(0));
      b_queue.delete();
    end
    @(posedge clock);
    #1;
  endtask

  // stall_after: number of beats after which r_ready drops for 3 cycles (-1: never).
  task automatic applyStimulus_read(input logic [32:0] addr, input logic [1:0] burst,
                                    input logic [2:0] size, input logic [3:0] len,
                                    input logic [5:0] id, input int stall_after);
    logic err;
    int   idx;
    int   n;
    int   start_seen;
    err = spec_error(burst, size, addr);
    idx = int'(addr[5 +: DEPTH_LOG2]);
    for (int beat = 0; beat <= int'(len); beat++) begin
      r_queue.push_back('{data: err ? 256'd0 : ref_mem[idx], last: (beat == int'(len)),
                          id: id, resp: err ? 2'b10 : 2'b00});
      idx = (idx + 1) % DEPTH;
    end
    start_seen          = r_seen;
    io_axi_ar_valid      = 1'b1;
    io_axi_ar_bits_addr  = addr;
    io_axi_ar_bits_burst = burst;
    io_axi_ar_bits_size  = size;
    io_axi_ar_bits_len   = len;
    io_axi_ar_bits_id    = id;
    waitHandshake("ar", 2);
    io_axi_ar_valid = 1'b0;
    if (stall_after >= 0) begin
      n = 0;
      while (r_seen < start_seen + stall_after && n < TIMEOUT) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
      #1 io_axi_r_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 io_axi_r_ready = 1'b1;
    end
    n = 0;
    while (r_queue.size() != 0 && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    if (r_queue.size() != 0) begin
      checkOutput("r_timeout", 256'(r_queue.size()), 256'(0));
      r_queue.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [32:0] addr;
    logic [3:0]  len;
    reset                = 1'b1;
    io_axi_aw_valid      = 1'b0;
    io_axi_aw_bits_addr  = '0;
    io_axi_aw_bits_burst = 2'b01;
    io_axi_aw_bits_id    = '0;
    io_axi_aw_bits_len   = '0;
    io_axi_aw_bits_size  = 3'd5;
    io_axi_w_valid       = 1'b0;
    io_axi_w_bits_last   = 1'b0;
    io_axi_w_bits_data   = '0;
    io_axi_w_bits_strb   = '0;
    io_axi_b_ready       = 1'b1;
    io_axi_ar_valid      = 1'b0;
    io_axi_ar_bits_addr  = '0;
    io_axi_ar_bits_burst = 2'b01;
    io_axi_ar_bits_id    = '0;
    io_axi_ar_bits_len   = '0;
    io_axi_ar_bits_size  = 3'd5;
    io_axi_r_ready       = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_aw_ready", 256'(io_axi_aw_ready), 256'(0));
    checkOutput("rst_w_ready", 256'(io_axi_w_ready), 256'(0));
    checkOutput("rst_ar_ready", 256'(io_axi_ar_ready), 256'(0));
    checkOutput("rst_b_valid", 256'(io_axi_b_valid), 256'(0));
    checkOutput("rst_r_valid", 256'(io_axi_r_valid), 256'(0));
    checkOutput("rst_r_last", 256'(io_axi_r_bits_last), 256'(0));
    checkOutput("rst_r_data", io_axi_r_bits_data, 256'(0));
    checkOutput("rst_ids", 256'({io_axi_b_bits_id, io_axi_r_bits_id}), 256'(0));
    checkOutput("rst_resps", 256'({io_axi_b_bits_resp, io_axi_r_bits_resp}), 256'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("idle_aw_ready", 256'(io_axi_aw_ready), 256'(1));
    checkOutput("idle_ar_ready", 256'(io_axi_ar_ready), 256'(1));
    @(posedge clock);
    #1;

    $display("[TB] basic write and read back");
    applyStimulus_write(33'h100, 2'b01, 3'd5, 4'd1, 6'd3, 32'hFFFF_FFFF, 1, 1'b0, '0);
    applyStimulus_read(33'h100, 2'b01, 3'd5, 4'd1, 6'd5, -1);

    $display("[TB] byte strobes");
    applyStimulus_write(33'h280, 2'b01, 3'd5, 4'd0, 6'd1, 32'hFFFF_FFFF, 0, 1'b1, {256{1'b1}});
    applyStimulus_write(33'h280, 2'b01, 3'd5, 4'd0, 6'd2, 32'h0000_000F, 0, 1'b1, 256'd0);
    applyStimulus_read(33'h280, 2'b01, 3'd5, 4'd0, 6'd4, -1);
    checkOutput("strb_model", ref_mem[20], {{224{1'b1}}, 32'h0});

    $display("[TB] back-pressure on R");
    applyStimulus_write(33'h400, 2'b01, 3'd5, 4'd3, 6'd9, 32'hFFFF_FFFF, 3, 1'b0, '0);
    applyStimulus_read(33'h400, 2'b01, 3'd5, 4'd3, 6'd10, 1);

    $display("[TB] error responses");
    applyStimulus_write(33'h100, 2'b10, 3'd5, 4'd0, 6'd7, 32'hFFFF_FFFF, 0, 1'b0, '0);
    applyStimulus_read(33'h100, 2'b01, 3'd5, 4'd0, 6'd8, -1);
    applyStimulus_read(33'h1_FFFF_FFE0, 2'b01, 3'd5, 4'd0, 6'd11, -1);
    applyStimulus_read(33'h100, 2'b01, 3'd4, 4'd1, 6'd12, -1);
    applyStimulus_write(33'h600, 2'b01, 3'd5, 4'd1, 6'd13, 32'hFFFF_FFFF, 0, 1'b0, '0);
    applyStimulus_write(33'h640, 2'b01, 3'd5, 4'd1, 6'd14, 32'hFFFF_FFFF, -1, 1'b0, '0);

    $display("[TB] index wrap at top of memory");
    applyStimulus_write(33'((DEPTH - 1) * 32), 2'b01, 3'd5, 4'd1, 6'd15, 32'hFFFF_FFFF, 1, 1'b0, '0);
    applyStimulus_read(33'((DEPTH - 1) * 32), 2'b01, 3'd5, 4'd1, 6'd16, -1);

    $display("[TB] random bursts");
    for (int i = 0; i < 6; i++) begin
      addr = {18'd0, 10'($urandom_range(64, 120)), 5'($urandom)};
      len  = 4'($urandom_range(0, 3));
      applyStimulus_write(addr, 2'b01, 3'd5, len, 6'($urandom), 32'hFFFF_FFFF, int'(len), 1'b0, '0);
      applyStimulus_write(addr, 2'b01, 3'd5, len, 6'($urandom), $urandom, int'(len), 1'b0, '0);
      applyStimulus_read(addr, 2'b01, 3'd5, len, 6'($urandom), (i % 2 == 0) ? -1 : 0);
    end

    checkOutput("b_queue_empty", 256'(b_queue.size()), 256'(0));
    checkOutput("r_queue_empty", 256'(r_queue.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
